// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises the instruction-fetch port (A) and the data port (B) onto one
// single-ported memory. A small grant FSM picks a port, captures its request
// into local registers and drives the memory from those registers only, so a
// requester that misbehaves mid-transaction cannot disturb the memory side.
// Ties are broken round-robin using the winner of the previous tie.
// A one-cycle DONE bubble after every transaction lets the finished requester
// drop its strobe before the arbiter looks at the request lines again.

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port A (instruction fetch)
  input  logic                  read_a,
  input  logic                  write_a,
  input  logic [MASK_WIDTH-1:0] wmask_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  resp_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  // port B (data access)
  input  logic                  read_b,
  input  logic                  write_b,
  input  logic [MASK_WIDTH-1:0] wmask_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  resp_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  // physical memory
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_A = 2'd1;
  localparam logic [1:0] ST_SERVE_B = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]            state_r;
  logic [1:0]            state_next_s;
  logic                  last_grant_r;
  logic                  last_grant_next_s;
  logic                  req_a_s;
  logic                  req_b_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  serve_a_s;
  logic                  serve_b_s;
  logic                  serving_s;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [MASK_WIDTH-1:0] wmask_r;
  logic                  op_write_r;

  assign req_a_s = read_a | write_a;
  assign req_b_s = read_b | write_b;

  // Grant decision and next-state logic for the serialising FSM.
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    grant_a_s         = 1'b0;
    grant_b_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_a_s && req_b_s) begin
          // Tie: the port that lost the previous tie wins this one.
          if (last_grant_r == PORT_B) begin
            grant_a_s         = 1'b1;
            last_grant_next_s = PORT_A;
            state_next_s      = ST_SERVE_A;
          end else begin
            grant_b_s         = 1'b1;
            last_grant_next_s = PORT_B;
            state_next_s      = ST_SERVE_B;
          end
        end else if (req_a_s) begin
          grant_a_s    = 1'b1;
          state_next_s = ST_SERVE_A;
        end else if (req_b_s) begin
          grant_b_s    = 1'b1;
          state_next_s = ST_SERVE_B;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SERVE_A: begin
        if (mem_resp) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SERVE_A;
        end
      end
      ST_SERVE_B: begin
        if (mem_resp) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SERVE_B;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and round-robin history; reset makes the first tie go to A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= PORT_B;
    end else begin
      state_r      <= state_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // Capture the granted port's operands on the granting edge; hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r     <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      wmask_r    <= {MASK_WIDTH{1'b0}};
      op_write_r <= 1'b0;
    end else if (grant_a_s) begin
      addr_r     <= address_a;
      wdata_r    <= wdata_a;
      wmask_r    <= wmask_a;
      op_write_r <= write_a;  // write wins when both strobes are high
    end else if (grant_b_s) begin
      addr_r     <= address_b;
      wdata_r    <= wdata_b;
      wmask_r    <= wmask_b;
      op_write_r <= write_b;
    end else begin
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
      wmask_r    <= wmask_r;
      op_write_r <= op_write_r;
    end
  end

  // Outputs decode straight from the state register so that an asserted
  // reset clears them immediately, and the response reaches the requester
  // in the same cycle the memory completes.
  assign serve_a_s = (state_r == ST_SERVE_A);
  assign serve_b_s = (state_r == ST_SERVE_B);
  assign serving_s = serve_a_s | serve_b_s;

  assign mem_read    = serving_s & ~op_write_r;
  assign mem_write   = serving_s & op_write_r;
  assign mem_address = addr_r;
  assign mem_wdata   = wdata_r;
  assign mem_wmask   = wmask_r;

  assign resp_a  = serve_a_s & mem_resp;
  assign resp_b  = serve_b_s & mem_resp;
  assign rdata_a = resp_a ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign rdata_b = resp_b ? mem_rdata : {DATA_WIDTH{1'b0}};

endmodule
